alu_share_arb: RTL and testbench

Shares one 32-bit `alu` instance between `NREQ` requesters, for example the execute stage and an address/PC adder path. It uses a round-robin arbiter with a valid/ready request handshake. Each accepted operation is computed in the same cycle and captured in a single-entry result register. The result is returned to the winning requester through its own valid/ready response channel. The block sits between the stage-level requesters and the shared ALU, and is the only driver of the ALU inputs.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu.sv | 23 ++
 rtl/alu_share_arb.sv | 134 +++++++++++++
 tb/tb_alu_share_arb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, datapath width and the
// result-register state encoding used by the ALU sharing arbiter.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam int         ALU_W   = 32;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Codes above XOR have no ALU operation behind them.
  function automatic logic fun_illegal(input logic [3:0] fun);
    return (fun > ALU_XOR);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: add, subtract, and, xor; unknown codes give 0.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] aluA_i,
  input  logic [ALU_W-1:0] aluB_i,
  input  logic [3:0]       alufun_i,
  output logic [ALU_W-1:0] valE_o
);

  // Operation select.
  always_comb begin
    valE_o = {ALU_W{1'b0}};
    case (alufun_i)
      ALU_ADD: valE_o = aluA_i + aluB_i;
      ALU_SUB: valE_o = aluA_i - aluB_i;
      ALU_AND: valE_o = aluA_i & aluB_i;
      ALU_XOR: valE_o = aluA_i ^ aluB_i;
      default: valE_o = {ALU_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one ALU between NREQ requesters, with a single-entry
// result register returned over per-requester valid/ready response channels.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_aluA,
  input  logic [NREQ*W-1:0] req_aluB,
  input  logic [NREQ*4-1:0] req_alufun,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [W-1:0]      resp_valE,
  output logic              resp_err,
  output logic              busy
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [W-1:0]    val_q, val_d;
  logic            err_q, err_d;
  logic [PW-1:0]   win_s;
  logic            found_s;
  logic            slot_free_s;
  logic            accept_s;
  logic            err_s;
  logic [W-1:0]    alu_a_s, alu_b_s, alu_y_s;
  logic [3:0]      fun_s;
  int              idx_s;

  // Round-robin scan; walking downward lets the nearest requester to rr_q win.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_s = int'(rr_q) + k;
      if (idx_s >= NREQ) begin
        idx_s = idx_s - NREQ;
      end else begin
        idx_s = idx_s;
      end
      if (req_valid[idx_s]) begin
        win_s   = idx_s[PW-1:0];
        found_s = 1'b1;
      end else begin
        win_s   = win_s;
        found_s = found_s;
      end
    end
  end

  assign slot_free_s = (state_q == ST_EMPTY) | resp_ready[owner_q];
  // rst_n gating keeps req_ready low for the whole reset window.
  assign accept_s    = found_s & slot_free_s & rst_n;

  assign alu_a_s = req_aluA[int'(win_s)*W +: W];
  assign alu_b_s = req_aluB[int'(win_s)*W +: W];
  assign fun_s   = req_alufun[int'(win_s)*4 +: 4];
  assign err_s   = fun_illegal(fun_s);

  alu u_alu (
    .aluA_i   (alu_a_s),
    .aluB_i   (alu_b_s),
    .alufun_i (fun_s),
    .valE_o   (alu_y_s)
  );

  // Handshake outputs: one-hot grant and one-hot response valid.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (accept_s) begin
      req_ready[win_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
    if (state_q == ST_FULL) begin
      resp_valid[owner_q] = 1'b1;
    end else begin
      resp_valid = '0;
    end
  end

  // Next state: accept overrides drain so back-to-back ops keep the slot FULL.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    val_d   = val_q;
    err_d   = err_q;
    if (accept_s) begin
      state_d = ST_FULL;
      owner_d = win_s;
      rr_d    = (int'(win_s) == NREQ - 1) ? {PW{1'b0}} : (win_s + 1'b1);
      val_d   = err_s ? {W{1'b0}} : alu_y_s;
      err_d   = err_s;
    end else if ((state_q == ST_FULL) && resp_ready[owner_q]) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // State and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      owner_q <= {PW{1'b0}};
      rr_q    <= {PW{1'b0}};
      val_q   <= {W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == ST_FULL);
  assign resp_valE = val_q;
  assign resp_err  = err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed vector table, hand-written
// backpressure/reset sequences and a randomized run against a reference model.
module tb_alu_share_arb;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [N*32-1:0] req_aluA, req_aluB;
  logic [N*4-1:0]  req_alufun;
  logic [31:0]     resp_valE;
  logic            resp_err, busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_full;
  int          m_owner, m_rr;
  logic [31:0] m_val;
  logic        m_err;
  logic        pv[N];
  logic [31:0] pa[N], pb[N];
  logic [3:0]  pf[N];

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  fun;
    logic [31:0] exp_val;
    logic        exp_err;
  } vec_t;

  vec_t tbl[7];

  alu_share_arb #(.NREQ(N), .W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_aluA   (req_aluA),
    .req_aluB   (req_aluB),
    .req_alufun (req_alufun),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_valE  (resp_valE),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] f);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = pv[i];
      req_aluA[i*32 +: 32] = pa[i];
      req_aluB[i*32 +: 32] = pb[i];
      req_alufun[i*4 +: 4] = pf[i];
    end
  endtask

  task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] f);
    req_aluA[r*32 +: 32] = a;
    req_aluB[r*32 +: 32] = b;
    req_alufun[r*4 +: 4] = f;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    req_aluA   = '0;
    req_aluB   = '0;
    req_alufun = '0;
    m_full = 1'b0; m_owner = 0; m_rr = 0; m_val = 32'd0; m_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0; pa[i] = 32'd0; pb[i] = 32'd0; pf[i] = 4'd0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Model-checked run; entered and left at one time unit after a rising edge.
  task automatic run_random(input int n, input int pv_pct, input int rr_pct);
    int          g;
    bit          free;
    logic [N-1:0] exp_rdy, exp_rv;
    for (int cyc = 0; cyc < n; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && ($urandom_range(99) < pv_pct)) begin
          pv[i] = 1'b1;
          pa[i] = $urandom;
          pb[i] = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
          pf[i] = ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(3));
        end
        resp_ready[i] = ($urandom_range(99) < rr_pct);
      end
      drive();
      @(negedge clk);
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && pv[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
      free    = !m_full || resp_ready[m_owner];
      exp_rdy = '0;
      exp_rv  = '0;
      if (g >= 0 && free) exp_rdy[g] = 1'b1;
      if (m_full) exp_rv[m_owner] = 1'b1;
      chk("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rnd_resp_valid", 32'(resp_valid), 32'(exp_rv));
      chk("rnd_busy", 32'(busy), 32'(m_full));
      if (m_full) begin
        chk("rnd_valE", resp_valE, m_val);
        chk("rnd_err", 32'(resp_err), 32'(m_err));
      end
      @(posedge clk);
      #1;
      if (g >= 0 && free) begin
        m_full  = 1'b1;
        m_owner = g;
        m_val   = ref_alu(pa[g], pb[g], pf[g]);
        m_err   = (pf[g] > 4'd3);
        m_rr    = (g + 1) % N;
        pv[g]   = 1'b0;
      end else if (m_full && resp_ready[m_owner]) begin
        m_full = 1'b0;
      end
    end
  endtask

  initial begin
    logic [N-1:0] oh;
    tbl[0] = '{0, 32'd5,          32'd7,          4'h0, 32'd12,         1'b0};
    tbl[1] = '{1, 32'd0,          32'd1,          4'h1, 32'hFFFF_FFFF,  1'b0};
    tbl[2] = '{0, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'h3, 32'hFF00_FF00,  1'b0};
    tbl[3] = '{1, 32'hDEAD_BEEF,  32'h0F0F_0F0F,  4'h2, 32'h0E0D_0E0F,  1'b0};
    tbl[4] = '{0, 32'h1234_5678,  32'h1111_1111,  4'h9, 32'd0,          1'b1};
    tbl[5] = '{1, 32'hFFFF_FFFF,  32'd1,          4'h0, 32'd0,          1'b0};
    tbl[6] = '{0, 32'd10,         32'd3,          4'h1, 32'd7,          1'b0};

    // Reset state, with requests and response ready asserted
    rst_n      = 1'b0;
    req_valid  = '1;
    resp_ready = '1;
    req_aluA   = '0;
    req_aluB   = '0;
    req_alufun = '0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valE", resp_valE, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    do_reset();

    // Directed vector table: one op per entry, response taken immediately
    for (int v = 0; v < 7; v++) begin
      oh = '0;
      oh[tbl[v].req] = 1'b1;
      req_aluA = '0; req_aluB = '0; req_alufun = '0;
      set_op(tbl[v].req, tbl[v].a, tbl[v].b, tbl[v].fun);
      req_valid  = oh;
      resp_ready = '1;
      @(negedge clk);
      chk("tbl_req_ready", 32'(req_ready), 32'(oh));
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      chk("tbl_resp_valid", 32'(resp_valid), 32'(oh));
      chk("tbl_valE", resp_valE, tbl[v].exp_val);
      chk("tbl_err", 32'(resp_err), 32'(tbl[v].exp_err));
      chk("tbl_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("tbl_drained_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Backpressure: result held while owner stalls, req1 accepted on release
    do_reset();
    set_op(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'h3);
    req_valid = 2'b01;
    @(negedge clk);
    chk("bp_first_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 2'b10;
    set_op(1, 32'd3, 32'd4, 4'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid), 32'h1);
      chk("bp_valE_hold", resp_valE, 32'hFF00_FF00);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
    end
    resp_ready = 2'b01;
    @(negedge clk);
    chk("bp_release_grant", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    @(negedge clk);
    chk("bp_req1_valid", 32'(resp_valid), 32'h2);
    chk("bp_req1_valE", resp_valE, 32'd7);

    // Drain req1 while req0 is accepted in the same edge, then reset mid-op
    @(posedge clk);
    #1;
    resp_ready = 2'b10;
    set_op(0, 32'd1, 32'd1, 4'h0);
    req_valid = 2'b01;
    @(posedge clk);
    #1;
    resp_ready = 2'b00;
    req_valid  = 2'b11;
    @(negedge clk);
    chk("mid_full_owner0", 32'(resp_valid), 32'h1);
    chk("mid_valE", resp_valE, 32'd2);
    chk("mid_stall", 32'(req_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_next_grant", 32'(req_ready), 32'h1);
    chk("mid_rst_no_resp", 32'(resp_valid), 32'h0);
    @(posedge clk);
    #1;

    // Round-robin with everyone always requesting and always ready
    do_reset();
    run_random(12, 100, 100);

    // Randomized traffic with random backpressure
    do_reset();
    run_random(400, 60, 70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
